// File: rtl/stat_reg_16_if.sv
// Host register port: 5-bit address, 16-bit data, one-cycle write and read strobes.
interface stat_reg_16_if;
    logic [15:0] din;
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [15:0] dout;

    modport master (output din, output we, output re, output addr, input dout);
    modport slave  (input din, input we, input re, input addr, output dout);
endinterface

// File: rtl/stat_reg_16.sv
// FPGA-to-host status bank: saturating 32-bit event counters read as coherent lo/hi
// word pairs, a 16-bit sync edge counter, sticky saturation flags, freeze and clear.
module stat_reg_16 #(
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    stat_reg_16_if.slave  bus,
    input  logic          sample_valid,
    input  logic          spike_valid,
    input  logic          eof,
    input  logic          sync_in
);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] sample_cnt;
    logic [31:0] spike_cnt;
    logic [31:0] frame_cnt;
    logic [15:0] sync_cnt;
    logic [2:0]  flags;
    logic        freeze;
    logic        sync_prev;
    logic [15:0] shadow;
    logic [15:0] rdata;

    logic        ctrl_wr;
    logic        clear;
    logic        flag_wr;
    logic [2:0]  ev;
    logic [2:0]  sat_set;
    logic        sync_edge;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 32'd1;
    endfunction

    // True when one more event leaves the counter pinned at its maximum.
    function automatic logic at_limit(input logic [31:0] cnt);
        return (cnt[31:1] == 31'h7FFF_FFFF);
    endfunction

    assign ctrl_wr   = bus.we && (bus.addr == 5'd0);
    assign clear     = ctrl_wr && bus.din[1];
    assign flag_wr   = bus.we && (bus.addr == 5'd7);
    assign ev        = {eof, spike_valid, sample_valid} & {3{~freeze}};
    assign sat_set   = ev & {at_limit(frame_cnt), at_limit(spike_cnt), at_limit(sample_cnt)};
    assign sync_edge = sync_in && !sync_prev && !freeze;

    always_comb begin
        rdata = 16'h0000;
        case (bus.addr)
            5'd0:    rdata = {VERSION, 7'b0, freeze};
            5'd1:    rdata = sample_cnt[15:0];
            5'd3:    rdata = spike_cnt[15:0];
            5'd5:    rdata = frame_cnt[15:0];
            5'd2,
            5'd4,
            5'd6:    rdata = shadow;
            5'd7:    rdata = {13'b0, flags};
            5'd8:    rdata = sync_cnt;
            default: rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            spike_cnt  <= '0;
            frame_cnt  <= '0;
            sync_cnt   <= '0;
            flags      <= '0;
            freeze     <= 1'b0;
            sync_prev  <= 1'b0;
        end else begin
            // The edge detector keeps tracking during freeze so frozen edges are lost.
            sync_prev <= sync_in;
            if (ctrl_wr)
                freeze <= bus.din[0];
            if (clear) begin
                sample_cnt <= '0;
                spike_cnt  <= '0;
                frame_cnt  <= '0;
                sync_cnt   <= '0;
                flags      <= '0;
            end else begin
                if (ev[0])
                    sample_cnt <= sat_inc(sample_cnt);
                if (ev[1])
                    spike_cnt <= sat_inc(spike_cnt);
                if (ev[2])
                    frame_cnt <= sat_inc(frame_cnt);
                if (sync_edge)
                    sync_cnt <= sync_cnt + 16'd1;
                flags <= (flag_wr ? (flags & ~bus.din[2:0]) : flags) | sat_set;
            end
        end
    end

    // Read path: the lo read captures the matching hi word so the pair is coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout <= '0;
            shadow   <= '0;
        end else if (bus.re) begin
            bus.dout <= rdata;
            case (bus.addr)
                5'd1:    shadow <= sample_cnt[31:16];
                5'd3:    shadow <= spike_cnt[31:16];
                5'd5:    shadow <= frame_cnt[31:16];
                default: shadow <= shadow;
            endcase
        end
    end
endmodule

// File: tb/tb_stat_reg_16.sv
// Scoreboard bench for stat_reg_16: a count-level reference model queues expected read
// data at each read strobe; a monitor pops and compares one cycle later.
module tb_stat_reg_16;
    logic clk = 1'b0;
    logic rst;
    logic sample_valid, spike_valid, eof, sync_in;

    stat_reg_16_if bus ();

    stat_reg_16 #(.VERSION(8'h01)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sample_valid (sample_valid),
        .spike_valid  (spike_valid),
        .eof          (eof),
        .sync_in      (sync_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [4:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rd_pend  = 1'b0;

    // Reference model: plain counts, saturating at 2^32-1.
    localparam longint unsigned MAX32 = 64'h0000_0000_FFFF_FFFF;
    longint unsigned m_cnt [3];
    int              m_sync;
    bit [2:0]        m_flags;
    bit              m_freeze;
    bit [15:0]       m_shadow;
    bit              m_prev;
    bit              sync_lvl;

    always @(posedge clk) rd_pend <= bus.re;

    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                exp_t e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: dout=%h, no read outstanding", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dout !== e.val) begin
                        n_fail++;
                        $display("FAIL read_addr_%0d: dout=%h required=%h", e.addr, bus.dout, e.val);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] model_read(input logic [4:0] a);
        longint unsigned c;
        case (a)
            5'd0:             return {8'h01, 7'd0, m_freeze};
            5'd1, 5'd3, 5'd5: begin
                c = m_cnt[(a - 1) / 2] % 65536;
                return c[15:0];
            end
            5'd2, 5'd4, 5'd6: return m_shadow;
            5'd7:             return {13'd0, m_flags};
            5'd8:             return m_sync[15:0];
            default:          return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_sync   = 0;
        m_flags  = '0;
        m_freeze = 1'b0;
        m_shadow = '0;
        m_prev   = 1'b0;
    endtask

    // One bus cycle: drive inputs, queue the expected read, advance the model.
    task automatic step(input bit we, input bit re, input logic [4:0] a, input logic [15:0] d,
                        input bit sv, input bit spv, input bit ef, input bit sy);
        bit              clr;
        bit [2:0]        evs;
        longint unsigned hi;
        bus.we = we; bus.re = re; bus.addr = a; bus.din = d;
        sample_valid = sv; spike_valid = spv; eof = ef; sync_in = sy;
        if (re) begin
            exp_q.push_back('{val: model_read(a), addr: a});
            if (a == 5'd1 || a == 5'd3 || a == 5'd5) begin
                hi = m_cnt[(a - 1) / 2] / 65536;
                m_shadow = hi[15:0];
            end
        end
        clr = we && (a == 5'd0) && d[1];
        evs = {ef, spv, sv};
        if (clr) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_flags = '0;
            m_sync  = 0;
        end else begin
            if (we && a == 5'd7) m_flags = m_flags & ~d[2:0];
            for (int i = 0; i < 3; i++) begin
                if (evs[i] && !m_freeze) begin
                    if (m_cnt[i] < MAX32) m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == MAX32) m_flags[i] = 1'b1;
                end
            end
            if (sy && !m_prev && !m_freeze) m_sync = (m_sync + 1) % 65536;
        end
        m_prev = sy;
        if (we && a == 5'd0) m_freeze = d[0];
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b0, 1'b1, a, 16'h0, 1'b0, 1'b0, 1'b0, sync_lvl);
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, sync_lvl);
    endtask

    task automatic pulses(input int n, input bit sv, input bit spv, input bit ef);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 16'h0, sv, spv, ef, sync_lvl);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.din = '0;
        sample_valid = 1'b0; spike_valid = 1'b0; eof = 1'b0; sync_in = sync_lvl;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        summary();
        $fatal(1, "watchdog expired");
    end

    initial begin
        sync_lvl = 1'b0;
        do_reset(3);

        // Reset state of every mapped register.
        for (int a = 0; a <= 8; a++) rd(a[4:0]);

        // Coherent read: the hi word comes from the shadow taken at the lo read.
        pulses(65535, 1'b1, 1'b0, 1'b0);
        rd(5'd1);
        pulses(1, 1'b1, 1'b0, 1'b0);
        rd(5'd2);
        pulses(4464, 1'b1, 1'b0, 1'b0);
        rd(5'd1);
        rd(5'd2);
        for (int a = 3; a <= 8; a++) rd(a[4:0]);

        // Spike counter saturation and sticky flag behaviour.
        force dut.spike_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.spike_cnt;
        m_cnt[1] = 64'h0000_0000_FFFF_FFFE;
        pulses(3, 1'b0, 1'b1, 1'b0);
        rd(5'd3);
        rd(5'd4);
        rd(5'd7);
        step(1'b1, 1'b1, 5'd7, 16'h0002, 1'b0, 1'b0, 1'b0, sync_lvl);
        rd(5'd7);
        pulses(1, 1'b0, 1'b1, 1'b0);
        rd(5'd7);

        // Freeze drops events; edges seen while frozen are never counted later.
        pulses(2, 1'b0, 1'b0, 1'b1);
        wr(5'd0, 16'h0001);
        rd(5'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, i[0]);
        rd(5'd5);
        rd(5'd8);
        wr(5'd0, 16'h0000);
        pulses(1, 1'b0, 1'b0, 1'b1);
        rd(5'd5);
        rd(5'd8);

        // sync_cnt wraps from FFFF to 0000.
        force dut.sync_cnt = 16'hFFFF;
        #1;
        release dut.sync_cnt;
        m_sync = 65535;
        step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd(5'd8);
        pulses(3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        sync_lvl = 1'b0;
        rd(5'd8);

        // Clear beats a simultaneous increment.
        step(1'b1, 1'b0, 5'd0, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b0);
        foreach (exp_q[i]) ;
        for (int a = 0; a <= 8; a++) rd(a[4:0]);
        pulses(1, 1'b1, 1'b0, 1'b0);
        rd(5'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit          w, r;
            logic [4:0]  a;
            logic [15:0] d;
            w = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 1) == 1);
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
            d = 16'($urandom);
            if (a == 5'd0 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            sync_lvl = ($urandom_range(0, 2) == 0);
            step(w, r, a, d, 1'($urandom), 1'($urandom), 1'($urandom), sync_lvl);
        end
        wr(5'd0, 16'h0000);

        // Reset between lo and hi reads; a high sync_in just after reset is one edge.
        pulses(5, 1'b1, 1'b0, 1'b0);
        rd(5'd1);
        sync_lvl = 1'b1;
        do_reset(2);
        rd(5'd2);
        rd(5'd8);
        rd(5'd0);
        sync_lvl = 1'b0;

        pulses(3, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: outstanding=%0d required=0", exp_q.size());
        end
        summary();
        $finish;
    end
endmodule
